isa_dma_channel: RTL

- Single-channel, 8-bit, single-mode ISA DMA engine (8237-style channel) for one DRQ/DACK pair.
- Sits between the HPS-side memory fabric and the ISA bus bridge. Services the card's DRQ by running one DACK-qualified IOR/IOW cycle per request, moving each byte to or from system memory.
- Upstream: a memory master port. Downstream: the bridge's dack/ior/iow/aen/data conduit.

---
 rtl/isa_dma_channel.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/isa_dma_channel.sv
// Single-channel 8-bit single-mode ISA DMA engine (8237-style channel).
// Each synchronized DRQ request runs one DACK-qualified IOR/IOW cycle and
// moves one byte between the ISA card and system memory.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | channel disarmed, waiting for cfg_start
// ARMED     | waiting for a fresh synchronized DRQ
// MEM_RD    | memory read request for the byte headed to the card
// MEM_RDW   | waiting for memory read data
// SETUP     | dack/aen asserted ahead of the strobe
// STROBE    | ior or iow asserted
// HOLD      | strobe released, dack/aen/data still held
// MEM_WR    | writing the byte captured from the card to memory
// UPDATE    | advance address/count, terminal count handling
module isa_dma_channel #(
  parameter int ADDR_W        = 32,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 8,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_dir,
  input  logic              cfg_autoinit,
  input  logic [ADDR_W-1:0] cfg_mem_addr,
  input  logic [15:0]       cfg_count,
  output logic              busy,
  output logic              tc_pulse,
  input  logic              drq,
  output logic              dack,
  output logic              aen,
  output logic              ior,
  output logic              iow,
  input  logic [7:0]        isa_data_in,
  output logic [7:0]        isa_data_out,
  output logic              isa_data_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_waitrequest,
  input  logic              mem_readdatavalid
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ARMED   = 4'd1;
  localparam logic [3:0] S_MEM_RD  = 4'd2;
  localparam logic [3:0] S_MEM_RDW = 4'd3;
  localparam logic [3:0] S_SETUP   = 4'd4;
  localparam logic [3:0] S_STROBE  = 4'd5;
  localparam logic [3:0] S_HOLD    = 4'd6;
  localparam logic [3:0] S_MEM_WR  = 4'd7;
  localparam logic [3:0] S_UPDATE  = 4'd8;

  // Phase timers load "cycles - 1" and terminate at zero.
  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);

  logic [3:0]        state;
  logic              drq_meta, drq_s, rearm, abort_pend;
  logic              dir, autoinit;
  logic [ADDR_W-1:0] base_addr, cur_addr;
  logic [15:0]       base_count, cur_count;
  logic [7:0]        timer, data_byte;
  logic              abort_now;

  assign abort_now = abort_pend | cfg_abort;

  // Two-flop synchronizer for the asynchronous card request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drq_meta <= 1'b0;
      drq_s    <= 1'b0;
    end else begin
      drq_meta <= drq;
      drq_s    <= drq_meta;
    end
  end

  // One request = one transfer: a transfer may start only after drq_s was seen low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     rearm <= 1'b1;
    else if (!drq_s)                               rearm <= 1'b1;
    else if (state == S_ARMED && !cfg_abort)       rearm <= 1'b0;
  end

  // Abort during a transfer is deferred until the transfer has been written back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      abort_pend <= 1'b0;
    else if (state == S_IDLE || state == S_ARMED)   abort_pend <= 1'b0;
    else if (cfg_abort)                             abort_pend <= 1'b1;
  end

  // Channel sequencer, address/count bookkeeping and data byte capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      dir        <= 1'b0;
      autoinit   <= 1'b0;
      base_addr  <= '0;
      cur_addr   <= '0;
      base_count <= '0;
      cur_count  <= '0;
      timer      <= '0;
      data_byte  <= '0;
    end else begin
      case (state)
        S_IDLE: if (cfg_start) begin
          dir        <= cfg_dir;
          autoinit   <= cfg_autoinit;
          base_addr  <= cfg_mem_addr;
          cur_addr   <= cfg_mem_addr;
          base_count <= cfg_count;
          cur_count  <= cfg_count;
          state      <= S_ARMED;
        end
        S_ARMED: begin
          if (cfg_abort) state <= S_IDLE;
          else if (drq_s && rearm) begin
            state <= dir ? S_MEM_RD : S_SETUP;
            timer <= SETUP_LD;
          end
        end
        S_MEM_RD:  if (!mem_waitrequest) state <= S_MEM_RDW;
        S_MEM_RDW: if (mem_readdatavalid) begin
          data_byte <= mem_rdata;
          timer     <= SETUP_LD;
          state     <= S_SETUP;
        end
        S_SETUP: begin
          if (timer == 8'd0) begin
            timer <= STROBE_LD;
            state <= S_STROBE;
          end else timer <= timer - 8'd1;
        end
        S_STROBE: begin
          if (timer == 8'd0) begin
            if (!dir) data_byte <= isa_data_in;
            timer <= HOLD_LD;
            state <= S_HOLD;
          end else timer <= timer - 8'd1;
        end
        S_HOLD: begin
          if (timer == 8'd0) state <= dir ? S_UPDATE : S_MEM_WR;
          else timer <= timer - 8'd1;
        end
        S_MEM_WR: if (!mem_waitrequest) state <= S_UPDATE;
        S_UPDATE: begin
          cur_addr <= cur_addr + ADDR_W'(1);
          if (cur_count != 16'd0) begin
            cur_count <= cur_count - 16'd1;
            state     <= abort_now ? S_IDLE : S_ARMED;
          end else begin
            if (autoinit) begin
              cur_addr  <= base_addr;
              cur_count <= base_count;
            end
            state <= (autoinit && !abort_now) ? S_ARMED : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state only so an async reset clears them immediately.
  always_comb begin
    busy         = (state != S_IDLE);
    dack         = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
    aen          = dack;
    ior          = (state == S_STROBE) && !dir;
    iow          = (state == S_STROBE) && dir;
    isa_data_oe  = dack && dir;
    isa_data_out = isa_data_oe ? data_byte : 8'd0;
    mem_read     = (state == S_MEM_RD);
    mem_write    = (state == S_MEM_WR);
    mem_addr     = (mem_read || mem_write) ? cur_addr : '0;
    mem_wdata    = mem_write ? data_byte : 8'd0;
    tc_pulse     = (state == S_UPDATE) && (cur_count == 16'd0);
  end

endmodule
